// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants and types for the ALU sequencer.
//   - ALU opcodes the sequencer issues on its own (ADR0, ADR1, DEC, NOP)
//   - request kind encoding
//   - sequencer state enum
//   - default reset value of the status register P
package alu_seq_pkg;

  localparam logic [5:0] OpAdr0 = 6'h00;
  localparam logic [5:0] OpAdr1 = 6'h01;
  localparam logic [5:0] OpDec  = 6'h1C;
  localparam logic [5:0] OpNop  = 6'h3F;

  localparam logic [7:0] PResetDefault = 8'h24;

  typedef enum logic [1:0] {
    KindSimple = 2'd0,
    KindIndex  = 2'd1,
    KindBranch = 2'd2,
    KindRsvd   = 2'd3
  } req_kind_e;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StAdrLo,
    StAdrHi,
    StBrTest,
    StBrLo,
    StBrHi,
    StBrDec
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bus between the instruction decoder (master)
// and the ALU sequencer (slave).
//   req_*  : one operation, accepted on req_valid && req_ready
//   rsp_*  : single-cycle response pulse, no backpressure
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [5:0]  req_opcode;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [15:0] req_addr;
  logic        req_use_p;
  logic        req_flag_write;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_taken;

  modport master (
    output req_valid, req_kind, req_opcode, req_a, req_b, req_addr, req_use_p,
           req_flag_write,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_taken
  );

  modport slave (
    input  req_valid, req_kind, req_opcode, req_a, req_b, req_addr, req_use_p,
           req_flag_write,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_taken
  );
endinterface

// File: rtl/status_reg.sv
// status_reg: 8-bit processor status register with per-bit write enable.
//   clk, rst : clock, synchronous active-high reset (loads ResetVal)
//   we       : per-bit write enable
//   wdata    : write data
//   q        : current value; bit 5 always reads 1
module status_reg #(
  parameter logic [7:0] ResetVal = 8'h24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] we,
  input  logic [7:0] wdata,
  output logic [7:0] q
);

  logic [7:0] p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= ResetVal;
    end else begin
      p_q <= (p_q & ~we) | (wdata & we);
    end
  end

  assign q = p_q | 8'h20;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller that owns the ALU inputs and P.
// Runs SIMPLE ops (with optional flag commit), 16-bit indexed address
// computation and relative branch resolution, one request at a time.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : request/response handshake
//   p_out           : current P
//   alu_opcode/a/b, flags_in : ALU drive (flags_in is always P)
//   alu_out, flags_out, flags_ena, branch_valid : ALU returns
// Optional build macro ALU_SEQ_PAGE_SKIP_EN: skip the high-byte steps when the
// low-byte add does not cross a page.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] P_RESET = PResetDefault
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [7:0] p_out,
  output logic [5:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] flags_in,
  input  logic [7:0] alu_out,
  input  logic [7:0] flags_out,
  input  logic [7:0] flags_ena,
  input  logic       branch_valid
);

  state_e      state_q;
  logic [5:0]  opcode_q;
  logic [7:0]  a_q, b_q, lo_q, hi_q;
  logic [15:0] addr_q;
  logic        use_p_q, flag_write_q;
  logic        rsp_valid_q, rsp_taken_q;
  logic [7:0]  rsp_data_q;
  logic [15:0] rsp_addr_q;

  logic [7:0]  p_q, p_we, a_sel;
  logic        adr_skip, br_skip;
  req_kind_e   kind;

  assign kind = req_kind_e'(bus.req_kind);

  // Only EXEC commits flags; every other state leaves P untouched.
  assign p_we = (state_q == StExec && flag_write_q) ? flags_ena : 8'h00;

  status_reg #(
    .ResetVal(P_RESET)
  ) u_status_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (p_we),
    .wdata(flags_out),
    .q    (p_q)
  );

  assign p_out    = p_q;
  assign flags_in = p_q;
  assign a_sel    = use_p_q ? p_q : a_q;

`ifdef ALU_SEQ_PAGE_SKIP_EN
  // No carry: high byte is the base high byte.
  assign adr_skip = ~flags_out[0];
  // Carry cancels sign extension: high byte is the PC high byte.
  assign br_skip  = (flags_out[0] == b_q[7]);
`else
  assign adr_skip = 1'b0;
  assign br_skip  = 1'b0;
`endif

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_taken = rsp_taken_q;

  always_comb begin
    alu_opcode = OpNop;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    case (state_q)
      StExec, StBrTest: begin
        alu_opcode = opcode_q;
        alu_a      = a_sel;
        alu_b      = b_q;
      end
      StAdrLo: begin
        alu_opcode = OpAdr0;
        alu_a      = addr_q[7:0];
        alu_b      = a_q;
      end
      StBrLo: begin
        alu_opcode = OpAdr0;
        alu_a      = addr_q[7:0];
        alu_b      = b_q;
      end
      StAdrHi, StBrHi: begin
        alu_opcode = OpAdr1;
        alu_b      = addr_q[15:8];
      end
      StBrDec: begin
        alu_opcode = OpDec;
        alu_a      = hi_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      opcode_q     <= OpNop;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      lo_q         <= 8'h00;
      hi_q         <= 8'h00;
      addr_q       <= 16'h0000;
      use_p_q      <= 1'b0;
      flag_write_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_taken_q  <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_addr_q   <= 16'h0000;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            opcode_q     <= (kind == KindRsvd) ? OpNop : bus.req_opcode;
            a_q          <= bus.req_a;
            b_q          <= bus.req_b;
            addr_q       <= bus.req_addr;
            use_p_q      <= bus.req_use_p;
            flag_write_q <= bus.req_flag_write;
            case (kind)
              KindIndex:  state_q <= StAdrLo;
              KindBranch: state_q <= StBrTest;
              default:    state_q <= StExec;
            endcase
          end
        end
        StExec: begin
          rsp_data_q  <= alu_out;
          rsp_taken_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        StAdrLo: begin
          lo_q <= alu_out;
          if (adr_skip) begin
            rsp_addr_q  <= {addr_q[15:8], alu_out};
            rsp_taken_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            state_q <= StAdrHi;
          end
        end
        StAdrHi: begin
          rsp_addr_q  <= {alu_out, lo_q};
          rsp_taken_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        StBrTest: begin
          if (!branch_valid) begin
            rsp_addr_q  <= addr_q;
            rsp_taken_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            state_q <= StBrLo;
          end
        end
        StBrLo: begin
          lo_q <= alu_out;
          if (br_skip) begin
            rsp_addr_q  <= {addr_q[15:8], alu_out};
            rsp_taken_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            state_q <= StBrHi;
          end
        end
        StBrHi: begin
          // Negative offset: ADR1 added only the carry, so the high byte
          // still needs the sign-extension decrement.
          if (b_q[7]) begin
            hi_q    <= alu_out;
            state_q <= StBrDec;
          end else begin
            rsp_addr_q  <= {alu_out, lo_q};
            rsp_taken_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StBrDec: begin
          rsp_addr_q  <= {alu_out, lo_q};
          rsp_taken_q <= 1'b1;
          rsp_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer. Provides a small
// behavioural ALU and checks responses against an arithmetic reference model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam logic [5:0] OpAdc = 6'h10;
  localparam logic [5:0] OpAnd = 6'h11;
  localparam logic [5:0] OpSec = 6'h18;
  localparam logic [5:0] OpClc = 6'h19;
  localparam logic [5:0] OpBcc = 6'h06;
  localparam logic [5:0] OpBeq = 6'h07;
  localparam logic [5:0] OpBne = 6'h08;
  localparam logic [5:0] OpBcs = 6'h0E;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if bus ();

  logic [7:0] p_out, alu_a, alu_b, flags_in, alu_out, flags_out, flags_ena;
  logic [5:0] alu_opcode;
  logic       branch_valid;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .p_out       (p_out),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .flags_in    (flags_in),
    .alu_out     (alu_out),
    .flags_out   (flags_out),
    .flags_ena   (flags_ena),
    .branch_valid(branch_valid)
  );

  // Behavioural ALU
  typedef struct packed {
    logic [7:0] res;
    logic [7:0] fo;
    logic [7:0] fe;
    logic       bv;
  } alu_res_t;

  function automatic alu_res_t alu_fn(input logic [5:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] p,
                                      input logic cin);
    alu_res_t   r;
    logic [8:0] s;
    logic [7:0] junk;
    junk  = ~(a ^ b);
    r.res = a;
    r.fo  = junk;
    r.fe  = 8'h00;
    r.bv  = 1'b0;
    case (op)
      OpAdr0: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[7:0];
        r.fo = {junk[7:1], s[8]};
        r.fe = 8'hFF;
      end
      OpAdr1: begin r.res = b + {7'd0, cin}; r.fe = 8'hFF; end
      OpDec:  begin r.res = a - 8'd1; r.fe = 8'hFF; end
      OpAdc: begin
        s = {1'b0, a} + {1'b0, b} + {8'd0, p[0]};
        r.res = s[7:0];
        r.fo = {s[7], (a[7] == b[7]) && (s[7] != a[7]), 4'b0000, s[7:0] == 8'h00, s[8]};
        r.fe = 8'hC3;
      end
      OpAnd: begin
        r.res = a & b;
        r.fo = {r.res[7], 5'b00000, r.res == 8'h00, 1'b0};
        r.fe = 8'h82;
      end
      OpSec: begin r.fo = 8'h01; r.fe = 8'h01; end
      OpClc: begin r.fo = 8'h00; r.fe = 8'h01; end
      OpBcc: r.bv = ~a[0];
      OpBcs: r.bv = a[0];
      OpBeq: r.bv = a[1];
      OpBne: r.bv = ~a[1];
      default: ;
    endcase
    return r;
  endfunction

  alu_res_t alu_r;
  logic     alu_carry_q;

  always_comb alu_r = alu_fn(alu_opcode, alu_a, alu_b, flags_in, alu_carry_q);
  assign alu_out      = alu_r.res;
  assign flags_out    = alu_r.fo;
  assign flags_ena    = alu_r.fe;
  assign branch_valid = alu_r.bv;

  always @(posedge clk) if (alu_opcode == OpAdr0) alu_carry_q <= alu_r.fo[0];

  // Reference model state
  logic [7:0]  m_p, m_data;
  logic [15:0] m_addr;
  int          n_pass = 0;
  int          n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic branch_taken(input logic [5:0] op, input logic [7:0] v);
    case (op)
      OpBcc:   return ~v[0];
      OpBcs:   return v[0];
      OpBeq:   return v[1];
      OpBne:   return ~v[1];
      default: return 1'b0;
    endcase
  endfunction

  task automatic predict(input logic [1:0] kind, input logic [5:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] addr, input logic use_p,
                         input logic fw, output int lat, output logic taken);
    logic [7:0]  av;
    logic [15:0] tgt;
    alu_res_t    r;
    av    = use_p ? m_p : a;
    taken = 1'b0;
    case (kind)
      2'd1: begin
        tgt    = addr + {8'd0, a};
        m_addr = tgt;
        lat    = 3;
`ifdef ALU_SEQ_PAGE_SKIP_EN
        if (tgt[15:8] == addr[15:8]) lat = 2;
`endif
      end
      2'd2: begin
        taken = branch_taken(op, av);
        if (!taken) begin
          m_addr = addr;
          lat    = 2;
        end else begin
          tgt    = addr + {{8{b[7]}}, b};
          m_addr = tgt;
          lat    = b[7] ? 5 : 4;
`ifdef ALU_SEQ_PAGE_SKIP_EN
          if (tgt[15:8] == addr[15:8]) lat = 3;
`endif
        end
      end
      default: begin
        r      = alu_fn((kind == 2'd3) ? OpNop : op, av, b, m_p, 1'b0);
        m_data = r.res;
        if (fw) m_p = ((m_p & ~r.fe) | (r.fo & r.fe)) | 8'h20;
        lat    = 2;
      end
    endcase
  endtask

  task automatic drive(input logic [1:0] kind, input logic [5:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] addr, input logic use_p,
                       input logic fw);
    bus.req_kind       = kind;
    bus.req_opcode     = op;
    bus.req_a          = a;
    bus.req_b          = b;
    bus.req_addr       = addr;
    bus.req_use_p      = use_p;
    bus.req_flag_write = fw;
    bus.req_valid      = 1'b1;
  endtask

  // Called just after an accepting edge; counts cycles to rsp_valid (bounded).
  task automatic wait_rsp(input string tag, input int lat, input logic taken);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.rsp_valid && cyc < 12);
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_data"}, {24'd0, bus.rsp_data}, {24'd0, m_data});
    check({tag, "_addr"}, {16'd0, bus.rsp_addr}, {16'd0, m_addr});
    check({tag, "_taken"}, {31'd0, bus.rsp_taken}, {31'd0, taken});
    check({tag, "_p"}, {24'd0, p_out}, {24'd0, m_p});
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic [1:0] kind, input logic [5:0] op,
                     input logic [7:0] a, input logic [7:0] b, input logic [15:0] addr,
                     input logic use_p, input logic fw);
    int   lat;
    logic taken;
    @(negedge clk);
    drive(kind, op, a, b, addr, use_p, fw);
    predict(kind, op, a, b, addr, use_p, fw, lat, taken);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp(tag, lat, taken);
  endtask

  logic [5:0] simple_ops[5] = '{OpAdc, OpAnd, OpSec, OpClc, OpNop};
  logic [5:0] br_ops[4]     = '{OpBcc, OpBcs, OpBeq, OpBne};

  initial begin
    int   lat;
    int   seen;
    logic taken;
    logic [1:0] k;
    logic [5:0] op;

    bus.req_valid = 1'b0;
    drive(2'd0, 6'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    m_p    = 8'h24;
    m_data = 8'h00;
    m_addr = 16'h0000;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_p", {24'd0, p_out}, 32'h24);
    check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_opcode", {26'd0, alu_opcode}, 32'h3F);
    check("rst_data", {24'd0, bus.rsp_data}, 32'd0);
    check("rst_addr", {16'd0, bus.rsp_addr}, 32'd0);

    // Directed cases
    txn("adc", 2'd0, OpAdc, 8'h7F, 8'h01, 16'h0000, 1'b0, 1'b1);
    check("adc_const_data", {24'd0, bus.rsp_data}, 32'h80);
    check("adc_const_p", {24'd0, p_out}, 32'hE4);
    txn("idx_cross", 2'd1, 6'h00, 8'h20, 8'h00, 16'h12F0, 1'b0, 1'b0);
    check("idx_cross_const", {16'd0, bus.rsp_addr}, 32'h1310);
    txn("idx_same", 2'd1, 6'h00, 8'h05, 8'h00, 16'h1200, 1'b0, 1'b0);
    check("idx_same_const", {16'd0, bus.rsp_addr}, 32'h1205);
    txn("idx_wrap", 2'd1, 6'h00, 8'h01, 8'h00, 16'hFFFF, 1'b0, 1'b0);
    txn("sec", 2'd0, OpSec, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1);
    txn("bcs_back", 2'd2, OpBcs, 8'h00, 8'hFE, 16'h1000, 1'b1, 1'b0);
    check("bcs_back_const", {16'd0, bus.rsp_addr}, 32'h0FFE);
    txn("bcc_not", 2'd2, OpBcc, 8'h00, 8'h10, 16'h1000, 1'b1, 1'b0);
    txn("br_fwd", 2'd2, OpBcc, 8'h00, 8'h30, 16'h10E0, 1'b0, 1'b0);
    txn("br_wrap", 2'd2, OpBcc, 8'h00, 8'hFF, 16'h0000, 1'b0, 1'b0);
    txn("rsvd", 2'd3, OpAdc, 8'h5A, 8'h11, 16'h0000, 1'b0, 1'b1);

    // Back-to-back: second request held valid across the first response
    @(negedge clk);
    drive(2'd0, OpAdc, 8'h05, 8'h03, 16'h0000, 1'b0, 1'b1);
    predict(2'd0, OpAdc, 8'h05, 8'h03, 16'h0000, 1'b0, 1'b1, lat, taken);
    @(posedge clk);
    #1 drive(2'd0, OpAnd, 8'hF0, 8'h3C, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_busy", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check("b2b_rsp1", {31'd0, bus.rsp_valid}, 32'd1);
    check("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
    check("b2b_data1", {24'd0, bus.rsp_data}, {24'd0, m_data});
    predict(2'd0, OpAnd, 8'hF0, 8'h3C, 16'h0000, 1'b0, 1'b1, lat, taken);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp("b2b2", lat, taken);

    // Reset in BR_LO aborts the branch
    txn("sec2", 2'd0, OpSec, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    drive(2'd2, OpBcc, 8'h00, 8'h10, 16'h2040, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_brlo", {26'd0, alu_opcode, alu_a}, {26'd0, OpAdr0, 8'h40});
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_p    = 8'h24;
    m_data = 8'h00;
    m_addr = 16'h0000;
    @(negedge clk);
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_p", {24'd0, p_out}, 32'h24);
    seen = bus.rsp_valid ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      k  = 2'($urandom_range(0, 3));
      op = (k == 2'd2) ? br_ops[$urandom_range(0, 3)] : simple_ops[$urandom_range(0, 4)];
      txn($sformatf("rnd%0d", i), k, op, 8'($urandom), 8'($urandom), 16'($urandom),
          1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
